// File: rtl/alu_pkg.sv
// Shared ALU definitions: default width, op_code encodings and flag bit positions.
package alu_pkg;

  localparam int N_DEFAULT    = 32;
  localparam int NREG_DEFAULT = 32;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_XOR = 4'b0010,
    OP_NOR = 4'b0011,
    OP_ADD = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111
  } op_e;

  localparam int FLAG_OVF  = 2;
  localparam int FLAG_EQ   = 1;
  localparam int FLAG_ZERO = 0;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational read ports, one write port, r0 hardwired to zero.
module regfile_2r1w
  import alu_pkg::*;
#(
  parameter int W     = N_DEFAULT,
  parameter int DEPTH = NREG_DEFAULT,
  parameter int ABITS = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [ABITS-1:0] ra_addr,
  output logic [W-1:0]     ra_data,
  input  logic [ABITS-1:0] rb_addr,
  output logic [W-1:0]     rb_data,
  input  logic             we,
  input  logic [ABITS-1:0] wa,
  input  logic [W-1:0]     wd
);

  logic [W-1:0] regs [DEPTH];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch (with writeback forwarding), registered EX stage feeding the external ALU,
// and a registered WB/result stage with valid/ready output and sticky overflow.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int N    = N_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [AW-1:0] in_rd,
  output logic [N-1:0]  alu_x,
  output logic [N-1:0]  alu_y,
  output logic [3:0]    alu_op,
  input  logic [N-1:0]  alu_z,
  input  logic          alu_ovf,
  input  logic          alu_eq,
  input  logic          alu_zero,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [N-1:0]  res_data,
  output logic [AW-1:0] res_rd,
  output logic [2:0]    res_flags,
  output logic          ovf_sticky
);

  logic          ex_valid;
  logic [AW-1:0] ex_rd;
  logic          wb_free;
  logic          ex_advance;
  logic          accept;
  logic          wr_en;
  logic [N-1:0]  rf_x;
  logic [N-1:0]  rf_y;
  logic [N-1:0]  fwd_x;
  logic [N-1:0]  fwd_y;
  logic [2:0]    flags_now;

  assign wb_free    = ~res_valid | res_ready;
  assign ex_advance = ex_valid & wb_free;
  assign in_ready   = ~ex_valid | wb_free;
  assign accept     = in_valid & in_ready;
  // Overflowing results are reported but never committed to the register file.
  assign wr_en      = ex_advance & (ex_rd != '0) & ~alu_ovf;

  regfile_2r1w #(.W(N), .DEPTH(NREG), .ABITS(AW)) u_rf (
    .clk     (clk),
    .rstb    (rstb),
    .ra_addr (in_rs),
    .ra_data (rf_x),
    .rb_addr (in_rt),
    .rb_data (rf_y),
    .we      (wr_en),
    .wa      (ex_rd),
    .wd      (alu_z)
  );

  // Bypass the value being written this edge so a dependent op issues with no bubble.
  assign fwd_x = (in_rs == '0) ? '0 : (wr_en && (ex_rd == in_rs)) ? alu_z : rf_x;
  assign fwd_y = (in_rt == '0) ? '0 : (wr_en && (ex_rd == in_rt)) ? alu_z : rf_y;

  always_comb begin
    flags_now            = '0;
    flags_now[FLAG_OVF]  = alu_ovf;
    flags_now[FLAG_EQ]   = alu_eq;
    flags_now[FLAG_ZERO] = alu_zero;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ex_valid <= 1'b0;
      ex_rd    <= '0;
      alu_x    <= '0;
      alu_y    <= '0;
      alu_op   <= '0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_rd    <= in_rd;
      alu_x    <= fwd_x;
      alu_y    <= fwd_y;
      alu_op   <= in_op;
    end else if (ex_advance) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_rd     <= '0;
      res_flags  <= '0;
      ovf_sticky <= 1'b0;
    end else if (ex_advance) begin
      res_valid  <= 1'b1;
      res_data   <= alu_z;
      res_rd     <= ex_rd;
      res_flags  <= flags_now;
      ovf_sticky <= ovf_sticky | alu_ovf;
    end else if (res_ready) begin
      res_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized scoreboard bench: a behavioural ALU drives the DUT's ALU port, and an in-order
// architectural register model predicts every result the stage must present.
module tb_alu_operand_stage;
  import alu_pkg::*;

  localparam logic [3:0] OP_LDI = 4'hF;  // reserved code; this bench's ALU returns an immediate

  logic        clk = 1'b0;
  logic        rstb;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [31:0] in_imm;
  logic [31:0] alu_x, alu_y, alu_z;
  logic [3:0]  alu_op;
  logic [2:0]  alu_f;
  logic        alu_ovf, alu_eq, alu_zero;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic [2:0]  res_flags;
  logic        ovf_sticky;
  logic [31:0] ex_imm = '0;
  logic        rand_bp = 1'b0;

  typedef struct packed {
    logic [31:0] z;
    logic [4:0]  rd;
    logic [2:0]  f;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mrf [32];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rstb(rstb),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
    .alu_z(alu_z), .alu_ovf(alu_ovf), .alu_eq(alu_eq), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .res_flags(res_flags), .ovf_sticky(ovf_sticky)
  );

  // Behavioural ALU; returns z and {ovf, eq, zero}.
  function automatic void alu_fn(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] imm, output logic [31:0] z, output logic [2:0] f);
    logic ovf;
    ovf = 1'b0;
    case (op)
      OP_AND: z = x & y;
      OP_OR:  z = x | y;
      OP_XOR: z = x ^ y;
      OP_NOR: z = ~(x | y);
      OP_ADD: begin z = x + y; ovf = (x[31] == y[31]) && (z[31] != x[31]); end
      OP_SUB: begin z = x - y; ovf = (x[31] != y[31]) && (z[31] != x[31]); end
      OP_SLT: z = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      OP_LDI: z = imm;
      default: z = ~(x & y);
    endcase
    f = {ovf, x == y, z == 32'd0};
  endfunction

  always_comb alu_fn(alu_op, alu_x, alu_y, ex_imm, alu_z, alu_f);
  assign alu_ovf  = alu_f[2];
  assign alu_eq   = alu_f[1];
  assign alu_zero = alu_f[0];

  // The immediate travels alongside the op that is in EX.
  always @(posedge clk) if (in_valid && in_ready) ex_imm <= in_imm;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Architectural, in-order execution of one accepted op.
  task automatic model_exec(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [31:0] imm);
    exp_t e;
    logic [31:0] z;
    logic [2:0] f;
    alu_fn(op, mrf[rs], mrf[rt], imm, z, f);
    e.z = z; e.rd = rd; e.f = f;
    exp_q.push_back(e);
    if (rd != 5'd0 && !f[2]) mrf[rd] = z;
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input int rs, input int rt, input int rd,
                       input logic [31:0] imm, output int stalls);
    bit done;
    done = 0; stalls = 0;
    in_valid = 1'b1; in_op = op; in_rs = rs[4:0]; in_rt = rt[4:0]; in_rd = rd[4:0]; in_imm = imm;
    for (int c = 0; c < 60 && !done; c++) begin
      if (rand_bp) res_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_ready) begin
        model_exec(op, rs[4:0], rt[4:0], rd[4:0], imm);
        $display("issue op=%0h rs=%0d rt=%0d rd=%0d imm=0x%0h stalls=%0d", op, rs, rt, rd, imm, stalls);
        done = 1;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int c;
    res_ready = 1'b1;
    c = 0;
    while ((exp_q.size() != 0 || res_valid) && c < 200) begin
      @(posedge clk); #1; c++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every cycle with a presented result is compared to the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rstb === 1'b1 && res_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {24'd0, res_data, res_rd, res_flags}, 64'd0);
        end else begin
          chk("result", {24'd0, res_data, res_rd, res_flags}, {24'd0, exp_q[0]});
          if (res_ready) begin
            $display("result rd=%0d data=0x%0h flags=%03b", res_rd, res_data, res_flags);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic reset_model();
    exp_q.delete();
    for (int i = 0; i < 32; i++) mrf[i] = '0;
  endtask

  task automatic check_rf_clear(input string name);
    logic [31:0] acc;
    acc = '0;
    for (int i = 1; i < 32; i++) acc = acc | dut.u_rf.regs[i];
    chk(name, 64'(acc), 64'd0);
  endtask

  task automatic random_ops(input int count);
    logic [3:0] ops [10];
    logic [31:0] imm;
    int s;
    ops = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ADD, OP_SUB, OP_SLT, OP_LDI, 4'h4, 4'h8};
    rand_bp = 1'b1;
    for (int i = 0; i < count; i++) begin
      case ($urandom_range(0, 3))
        0: imm = 32'h7FFF_FFFF;
        1: imm = 32'h8000_0000;
        default: imm = $urandom;
      endcase
      issue(ops[$urandom_range(0, 9)], $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), imm, s);
    end
    rand_bp = 1'b0;
    drain();
  endtask

  initial begin
    int s;
    reset_model();
    rstb = 1'b0; in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_imm = '0; res_ready = 1'b1;
    #12;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_ovf_sticky", 64'(ovf_sticky), 64'd0);
    chk("rst_alu_x", 64'(alu_x), 64'd0);
    check_rf_clear("rst_rf");
    @(negedge clk); rstb = 1'b1;
    @(posedge clk); #1;

    // r1=5, r2=3; r3=r1+r2 followed immediately by dependent r4=r3+r3
    issue(OP_LDI, 0, 0, 1, 32'd5, s);
    issue(OP_LDI, 0, 0, 2, 32'd3, s);
    issue(OP_ADD, 1, 2, 3, 32'd0, s);
    chk("fwd_first_stalls", 64'(s), 64'd0);
    issue(OP_ADD, 3, 3, 4, 32'd0, s);
    chk("fwd_dep_stalls", 64'(s), 64'd0);
    drain();
    chk("r3_value", 64'(dut.u_rf.regs[3]), 64'd8);
    chk("r4_value", 64'(dut.u_rf.regs[4]), 64'd16);

    // Two-edge latency from accept to res_valid
    issue(OP_ADD, 0, 4, 0, 32'd0, s);
    @(negedge clk);
    chk("lat_edge1_valid", 64'(res_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_edge2_valid", 64'(res_valid), 64'd1);
    @(posedge clk); #1;
    issue(OP_OR, 0, 0, 9, 32'd0, s);   // r0 still reads 0
    issue(OP_SUB, 0, 1, 10, 32'd0, s); // X=0 when rs=0
    drain();
    chk("sticky_before_ovf", 64'(ovf_sticky), 64'd0);

    // Overflow: reported with flags 100, r7 keeps its old value
    issue(OP_LDI, 0, 0, 5, 32'h7FFF_FFFF, s);
    issue(OP_LDI, 0, 0, 6, 32'd1, s);
    issue(OP_LDI, 0, 0, 7, 32'h0000_1234, s);
    issue(OP_ADD, 5, 6, 7, 32'd0, s);
    issue(OP_OR, 7, 0, 8, 32'd0, s);
    drain();
    chk("ovf_sticky_set", 64'(ovf_sticky), 64'd1);
    chk("r7_unchanged", 64'(dut.u_rf.regs[7]), 64'h1234);

    // Backpressure: two accepts, then in_ready must drop with both stages full
    res_ready = 1'b0;
    issue(OP_ADD, 1, 2, 11, 32'd0, s);
    issue(OP_XOR, 11, 1, 12, 32'd0, s);
    in_valid = 1'b1; in_op = OP_AND; in_rs = 5'd12; in_rt = 5'd2; in_rd = 5'd13;
    @(negedge clk);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_in_ready_still_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    issue(OP_AND, 12, 2, 13, 32'd0, s);
    drain();

    random_ops(300);

    // Asynchronous reset mid-stream
    issue(OP_LDI, 0, 0, 1, 32'hDEAD_BEEF, s);
    issue(OP_ADD, 5, 6, 2, 32'd0, s);
    issue(OP_ADD, 1, 1, 3, 32'd0, s);
    #1 rstb = 1'b0;
    #1;
    chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_ovf_sticky", 64'(ovf_sticky), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check_rf_clear("mid_rst_rf");
    reset_model();
    @(negedge clk); #1 rstb = 1'b1;
    @(posedge clk); #1;
    issue(OP_LDI, 0, 0, 1, 32'd5, s);
    issue(OP_ADD, 1, 1, 2, 32'd0, s);
    drain();
    chk("restart_r2", 64'(dut.u_rf.regs[2]), 64'd10);
    random_ops(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
